// File: rtl/regfile_wb_scheduler.sv
// Write-port arbiter between pipeline writeback and the multi-cycle result path,
// plus a pending-destination scoreboard that raises RAW/WAW hazards to decode.
module regfile_wb_scheduler #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mc_issue_valid,
    input  logic [4:0]  mc_issue_rd,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    input  logic [4:0]  chk_rd,
    output logic        hazard,
    output logic        mc_busy,
    input  logic        pipe_wb_valid,
    input  logic [4:0]  pipe_wb_rd,
    input  logic [31:0] pipe_wb_data,
    output logic        pipe_stall,
    input  logic        mc_wb_valid,
    input  logic [4:0]  mc_wb_rd,
    input  logic [31:0] mc_wb_data,
    output logic        mc_wb_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    logic        buf_valid;
    logic [4:0]  buf_rd;
    logic [31:0] buf_data;
    logic [3:0]  wait_cnt;
    logic [31:1] pending;

    logic        accept;
    logic        pipe_go;
    logic        buf_go;
    logic        buf_wr;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;
    logic [31:0] live;

    assign mc_wb_ready = !buf_valid;
    assign accept      = mc_wb_valid && !buf_valid;
    assign pipe_stall  = buf_valid && (wait_cnt >= LIM);

    // pipe_go already excludes a stall, so the buffer wins whenever pipe does not
    assign pipe_go = !pipe_stall && pipe_wb_valid
                   && (pipe_wb_rd != 5'd0);
    assign buf_go  = buf_valid && !pipe_go;
    assign buf_wr  = buf_go && (buf_rd != 5'd0);

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        unique case (1'b1)
            pipe_go: begin
                rf_we    = 1'b1;
                rf_waddr = pipe_wb_rd;
                rf_wdata = pipe_wb_data;
            end
            buf_wr: begin
                rf_we    = 1'b1;
                rf_waddr = buf_rd;
                rf_wdata = buf_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        set_vec = 32'd0;
        clr_vec = 32'd0;
        if (mc_issue_valid && (mc_issue_rd != 5'd0))
            set_vec[mc_issue_rd] = 1'b1;
        if (buf_wr)
            clr_vec[buf_rd] = 1'b1;
    end

    // A bit retiring this cycle is bypassed by the register file, so mask it
    assign live = {pending, 1'b0} & ~clr_vec;

    assign hazard  = live[chk_rs1] | live[chk_rs2] | live[chk_rd];
    assign mc_busy = |pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_rd    <= 5'd0;
            buf_data  <= 32'd0;
            wait_cnt  <= 4'd0;
            pending   <= '0;
        end else begin
            if (buf_go) begin
                buf_valid <= 1'b0;
                wait_cnt  <= 4'd0;
            end else if (buf_valid) begin
                if (wait_cnt != 4'hf)
                    wait_cnt <= wait_cnt + 4'd1;
            end else if (accept) begin
                buf_valid <= 1'b1;
                buf_rd    <= mc_wb_rd;
                buf_data  <= mc_wb_data;
                wait_cnt  <= 4'd0;
            end
            pending <= (pending & ~clr_vec[31:1]) | set_vec[31:1];
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench: stimulus pushes model predictions, a negedge monitor
// pops and compares them against the scheduler outputs.
module tb_regfile_wb_scheduler;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mc_issue_valid = 1'b0;
    logic [4:0]  mc_issue_rd = '0;
    logic [4:0]  chk_rs1 = '0, chk_rs2 = '0, chk_rd = '0;
    logic        hazard, mc_busy;
    logic        pipe_wb_valid = 1'b0;
    logic [4:0]  pipe_wb_rd = '0;
    logic [31:0] pipe_wb_data = '0;
    logic        pipe_stall;
    logic        mc_wb_valid = 1'b0;
    logic [4:0]  mc_wb_rd = '0;
    logic [31:0] mc_wb_data = '0;
    logic        mc_wb_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .mc_issue_valid(mc_issue_valid), .mc_issue_rd(mc_issue_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .hazard(hazard), .mc_busy(mc_busy),
        .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd),
        .pipe_wb_data(pipe_wb_data), .pipe_stall(pipe_stall),
        .mc_wb_valid(mc_wb_valid), .mc_wb_rd(mc_wb_rd),
        .mc_wb_data(mc_wb_data), .mc_wb_ready(mc_wb_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    typedef struct {
        string       tag;
        logic [41:0] v;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int vectors = 0;
    int miscompares = 0;

    // staged stimulus
    bit        s_rst = 0;
    bit        s_iv = 0, s_pv = 0, s_mv = 0;
    int        s_ird = 0, s_rs1 = 0, s_rs2 = 0, s_rd = 0;
    int        s_prd = 0, s_mrd = 0;
    bit [31:0] s_pdat = 0, s_mdat = 0;
    string     s_tag = "idle";

    // reference model: a queue of buffered results and a set of pending regs
    int        m_rd[$];
    bit [31:0] m_dat[$];
    int        age = 0;
    bit        pend[32];
    bit        prev_stall = 0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if ({rf_we, rf_waddr, rf_wdata, pipe_stall,
                 mc_wb_ready, hazard, mc_busy} !== e.v) begin
                miscompares++;
                $display("FAIL %s t=%0t got we=%0b a=%0d d=%h st=%0b rdy=%0b hz=%0b busy=%0b want we=%0b a=%0d d=%h st=%0b rdy=%0b hz=%0b busy=%0b",
                    e.tag, $time, rf_we, rf_waddr, rf_wdata, pipe_stall,
                    mc_wb_ready, hazard, mc_busy, e.v[41], e.v[40:36],
                    e.v[35:4], e.v[3], e.v[2], e.v[1], e.v[0]);
            end
        end
    end

    function automatic void model_clear();
        m_rd.delete();
        m_dat.delete();
        age = 0;
        foreach (pend[i]) pend[i] = 0;
    endfunction

    task automatic step();
        bit bv, st, we, hz, busy;
        int src, clr, wa;
        bit [31:0] wd;
        int chks[3];
        @(posedge clk);
        #1;
        rst_n = !s_rst;
        if (s_rst) model_clear();
        bv = (m_rd.size() > 0);
        st = bv && (age >= LIMIT);
        if (st) src = 2;
        else if (s_pv && s_prd != 0) src = 1;
        else if (bv) src = 2;
        else src = 0;
        we = 0; wa = 0; wd = 0; clr = -1;
        if (src == 1) begin
            we = 1; wa = s_prd; wd = s_pdat;
        end else if (src == 2 && m_rd[0] != 0) begin
            we = 1; wa = m_rd[0]; wd = m_dat[0]; clr = m_rd[0];
        end
        chks = '{s_rs1, s_rs2, s_rd};
        hz = 0;
        foreach (chks[i])
            if (chks[i] != 0 && pend[chks[i]] && chks[i] != clr) hz = 1;
        busy = 0;
        foreach (pend[i]) busy |= pend[i];
        // issue logic never issues into a hazard or onto a live pending reg
        if (hz || (pend[s_ird] && s_ird != clr)) s_iv = 0;
        mc_issue_valid = s_iv;
        mc_issue_rd    = 5'(s_ird);
        chk_rs1 = 5'(s_rs1); chk_rs2 = 5'(s_rs2); chk_rd = 5'(s_rd);
        pipe_wb_valid = s_pv; pipe_wb_rd = 5'(s_prd); pipe_wb_data = s_pdat;
        mc_wb_valid = s_mv; mc_wb_rd = 5'(s_mrd); mc_wb_data = s_mdat;
        q.push_back('{s_tag, {we, 5'(wa), wd, st, !bv, hz, busy}});
        prev_stall = st;
        if (!s_rst) begin
            if (src == 2) begin
                void'(m_rd.pop_front());
                void'(m_dat.pop_front());
                age = 0;
            end else if (bv) begin
                if (age < 15) age++;
            end else if (s_mv) begin
                m_rd.push_back(s_mrd);
                m_dat.push_back(s_mdat);
                age = 0;
            end
            if (clr > 0) pend[clr] = 0;
            if (s_iv && s_ird != 0) pend[s_ird] = 1;
        end
    endtask

    task automatic idle();
        s_iv = 0; s_pv = 0; s_mv = 0;
        s_ird = 0; s_rs1 = 0; s_rs2 = 0; s_rd = 0;
        s_prd = 0; s_mrd = 0; s_pdat = 0; s_mdat = 0;
    endtask

    initial begin
        model_clear();
        s_tag = "reset"; s_rst = 1; idle();
        repeat (2) step();
        s_rst = 0;
        repeat (2) step();

        s_tag = "lifecycle";
        s_iv = 1; s_ird = 5; step();
        idle(); s_rs1 = 5; step();
        s_mv = 1; s_mrd = 5; s_mdat = 32'hDEADBEEF; step();
        s_mv = 0; step();
        step();
        idle(); step();

        s_tag = "starve";
        s_iv = 1; s_ird = 7; step();
        idle();
        s_pv = 1; s_prd = 3; s_pdat = 32'h3333_0003;
        s_mv = 1; s_mrd = 7; s_mdat = 32'h7777_7777; s_rd = 7;
        step();
        s_mv = 0;
        repeat (7) step();
        idle(); step();

        s_tag = "x0";
        s_pv = 1; s_prd = 0; s_pdat = 32'h1234_5678;
        s_mv = 1; s_mrd = 11; s_mdat = 32'hB0B0_1111;
        step();
        s_mv = 0; step();
        s_mv = 1; s_mrd = 0; s_mdat = 32'h5A5A_5A5A; step();
        s_mv = 0; step();
        idle(); s_iv = 1; s_ird = 0; step();
        idle(); s_rs1 = 0; step();
        step();

        s_tag = "setclr";
        idle(); s_iv = 1; s_ird = 9; step();
        idle(); s_mv = 1; s_mrd = 9; s_mdat = 32'h0909_0909; step();
        idle(); s_iv = 1; s_ird = 9; step();
        idle(); s_rs2 = 9; step();
        idle(); s_mv = 1; s_mrd = 9; s_mdat = 32'h9999_0000; step();
        idle(); step();
        step();

        s_tag = "midreset";
        s_iv = 1; s_ird = 4; step();
        s_ird = 12; step();
        idle(); s_pv = 1; s_prd = 2; s_pdat = 32'h2222;
        s_mv = 1; s_mrd = 4; s_mdat = 32'hCAFE_F00D; step();
        idle(); s_rst = 1; s_rs1 = 4; s_rs2 = 12; step();
        step();
        s_rst = 0; s_rs1 = 0; s_rs2 = 0; step();
        repeat (4) step();

        s_tag = "random";
        for (int n = 0; n < 3000; n++) begin
            if (!prev_stall) begin
                s_pv   = ($urandom_range(0, 2) != 0);
                s_prd  = $urandom_range(0, 31);
                s_pdat = $urandom;
            end
            s_iv   = ($urandom_range(0, 3) == 0);
            s_ird  = $urandom_range(0, 31);
            s_rs1  = $urandom_range(0, 31);
            s_rs2  = $urandom_range(0, 31);
            s_rd   = $urandom_range(0, 31);
            s_mv   = ($urandom_range(0, 2) == 0);
            s_mrd  = $urandom_range(0, 31);
            s_mdat = $urandom;
            s_rst  = ($urandom_range(0, 499) == 0);
            step();
        end
        s_rst = 0; idle(); s_tag = "tail";
        repeat (3) step();

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
